mux8_rr_sched: RTL
==================

Name: mux8_rr_sched

Overview:
- Round-robin scheduler that shares one 8:1 single-bit mux among 8 requesters.
- Drives the mux select and a one-hot grant.
- Bounds each owner's tenure to HOLD_MAX cycles.
- Inserts one dead cycle between owners.
- Registers the mux output as a qualified data stream for the downstream consumer.

Parameters:
- HOLD_MAX, 4, maximum consecutive GRANT cycles per tenure (legal range 1..15)
- CNT_W, 4, tenure counter width; must satisfy 2^CNT_W > HOLD_MAX

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  scheduler enable; 0 blocks new grants and ends the current tenure
- req  input  8  level request per requester; bit n = requester n
- mux_q  input  1  output of the shared 8:1 mux (combinational function of sel)
- sel  output  3  registered select driven to the mux
- gnt  output  8  registered one-hot grant; all-zero when no owner
- busy  output  1  registered; 1 while in GRANT
- data_out  output  1  registered sample of mux_q
- data_valid  output  1  registered; 1 for exactly one cycle per captured sample

Behaviour:
- States: IDLE, GRANT, RELEASE.
- Internal state:
  - ptr[2:0]: next-priority index.
  - owner[2:0].
  - cnt[CNT_W-1:0].
- Reset, when rst is sampled 1:
  - state=IDLE, ptr=0, owner=0, cnt=0.
  - sel=0, gnt=0, busy=0, data_out=0, data_valid=0.
  - Reset overrides every other event, including mid-GRANT.
- Arbitration, evaluated in IDLE or RELEASE when en=1 and req!=0:
  - The winner is the first set req bit scanning ptr, ptr+1, ..., ptr+7, indices mod 8.
  - At the next edge: state=GRANT, owner=winner, sel=winner, gnt=1<<winner, busy=1, cnt=1.
  - Request-to-grant latency is one clock.
- IDLE:
  - No winner: remain in IDLE.
  - sel holds its last value; it does not return to 0, to keep the mux stable.
- GRANT: evaluated every cycle.
  - Capture:
    - If req[owner]=1: data_out<=mux_q, data_valid<=1.
    - Otherwise data_valid<=0.
  - Exit to RELEASE at the next edge if any of these holds:
    - req[owner]=0
    - cnt==HOLD_MAX
    - en=0
  - On exit:
    - gnt<=0, busy<=0.
    - ptr<=owner+1, wrapping 7->0.
    - sel is held.
  - Otherwise: cnt<=cnt+1 and remain in GRANT.
  - Priority of exit causes is irrelevant; all produce the same transition.
- RELEASE: always exactly one cycle with gnt=0.
  - data_valid<=0.
  - If a winner exists per the arbitration rule: go to GRANT.
  - Otherwise: go to IDLE.
  - Minimum gap between tenures is therefore exactly one cycle.
  - A continuously requesting sole requester is re-granted after that one-cycle gap.
- Outside GRANT, data_valid is 0. data_out holds its last value when data_valid=0.
- Fairness:
  - With all 8 requesting continuously, grant order is 0,1,...,7,0.
  - Each owner gets HOLD_MAX cycles.
  - Period is 8*(HOLD_MAX+1) cycles.
- Requests that rise while another owner holds the grant are not latched. They must stay asserted until granted.
- gnt is always one-hot or zero.
- busy == (gnt != 0) at all times.

Test Plan:
1. rst=1 for 2 cycles, then req=8'h01 held, en=1:
   - gnt=8'h01, sel=0 one cycle after req.
   - busy high for 4 cycles, then 1 cycle gnt=0.
   - Then gnt=8'h01 again; pattern repeats with period 5.
2. req=8'hFF held, en=1:
   - Grant sequence 01,02,04,...,80,01, each 4 cycles with a 1-cycle gap.
   - sel tracks 0..7.
   - 40-cycle period.
3. req=8'h28, owner 3 drops req[3] after 2 GRANT cycles:
   - RELEASE for 1 cycle.
   - Then gnt=8'h20, sel=5, cnt restarts at 1.
4. Data path: bench drives mux_q from an 8:1 mux model with i=8'b1010_0101, req=8'h04:
   - data_out=1 with data_valid=1 for 4 consecutive cycles, each one cycle after the GRANT cycle.
   - data_valid=0 in the RELEASE cycle.
   - Repeat with req=8'h02: data_out=0.
5. en dropped to 0 on the 2nd GRANT cycle of owner 6, with req=8'h40 held:
   - RELEASE, then IDLE; gnt stays 0 while en=0.
   - After en=1: gnt=8'h40 one cycle later.
6. rst pulsed during GRANT of owner 7, then req=8'h81:
   - All outputs 0 the cycle after the rst edge.
   - First grant goes to requester 0 (ptr reset), then requester 7 after HOLD_MAX+1 cycles.

Source files
------------

// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler sharing one 8:1 single-bit mux among 8 requesters.
// Bounded tenures, one dead cycle between owners, registered data capture.
module mux8_rr_sched #(
  parameter int unsigned HOLD_MAX = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       mux_q,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       busy,
  output logic       data_out,
  output logic       data_valid
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic [7:0]       gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;

  logic             win_found_s;
  logic [2:0]       win_idx_s;
  logic             tenure_end_s;

  // Returns {found, index} of the first set request scanning upward from p.
  // Iterating from the far end lets the nearest hit overwrite the result.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'd0;
    for (int k = 7; k >= 0; k--) begin
      idx = p + 3'(k);
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Winner selection and tenure termination conditions.
  always_comb begin
    {win_found_s, win_idx_s} = rr_pick(req, ptr_q);
    tenure_end_s = (!req[owner_q]) || (cnt_q == CNT_W'(HOLD_MAX)) || (!en);
  end

  // Next-state and next-output computation.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    gnt_d        = gnt_q;
    busy_d       = busy_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_RELEASE: begin
        if (en && win_found_s) begin
          state_d = ST_GRANT;
          owner_d = win_idx_s;
          sel_d   = win_idx_s;
          gnt_d   = 8'd1 << win_idx_s;
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(1);
        end else begin
          state_d = ST_IDLE;
          gnt_d   = 8'd0;
          busy_d  = 1'b0;
        end
      end
      ST_GRANT: begin
        if (req[owner_q]) begin
          data_out_d   = mux_q;
          data_valid_d = 1'b1;
        end else begin
          data_valid_d = 1'b0;
        end
        // sel is deliberately held across the release so the mux stays quiet.
        if (tenure_end_s) begin
          state_d = ST_RELEASE;
          gnt_d   = 8'd0;
          busy_d  = 1'b0;
          ptr_d   = owner_q + 3'd1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 8'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= 3'd0;
      owner_q      <= 3'd0;
      cnt_q        <= '0;
      sel_q        <= 3'd0;
      gnt_q        <= 8'd0;
      busy_q       <= 1'b0;
      data_out_q   <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      gnt_q        <= gnt_d;
      busy_q       <= busy_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign sel        = sel_q;
  assign gnt        = gnt_q;
  assign busy       = busy_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;

endmodule
